// File: rtl/register_pipeline_variable_pkg.sv
// rtl/register_pipeline_variable_pkg.sv - shared state encoding and width helper for the pipeline sequencer
package register_pipeline_variable_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/register_pipeline_variable_fill_counter.sv
// rtl/register_pipeline_variable_fill_counter.sv - saturating occupancy counter with synchronous clear
module register_pipeline_variable_fill_counter #(
  parameter int MAX_COUNT = 16,
  parameter int WIDTH     = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count shifts into the pipeline, holding at MAX_COUNT once the pipeline is full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != WIDTH'(MAX_COUNT))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/register_pipeline_variable_sequencer.sv
// rtl/register_pipeline_variable_sequencer.sv - ready/valid and retune sequencer for a variable-tap SRL pipeline
module register_pipeline_variable_sequencer
  import register_pipeline_variable_pkg::*;
#(
  parameter int  PIPE_DEPTH  = 16,
  parameter int  DEFAULT_TAP = 0,
  localparam int ADDR_WIDTH  = clog2(PIPE_DEPTH),
  localparam int FILL_WIDTH  = clog2(PIPE_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ADDR_WIDTH-1:0] cfg_tap,
  input  logic                  cfg_flush,
  output logic                  pipe_shift_data,
  output logic                  pipe_clear,
  output logic                  pipe_tap_number_load,
  output logic [ADDR_WIDTH-1:0] pipe_tap_number,
  output logic                  busy
);

  if ((PIPE_DEPTH != 16) && (PIPE_DEPTH != 32)) begin : g_bad_depth
    $error("PIPE_DEPTH must be 16 or 32");
  end
  if ((DEFAULT_TAP < 0) || (DEFAULT_TAP >= PIPE_DEPTH)) begin : g_bad_tap
    $error("DEFAULT_TAP must be within 0..PIPE_DEPTH-1");
  end

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   tap;
  logic [FILL_WIDTH-1:0]   fill;
  logic [FILL_WIDTH-1:0]   drain_cnt;
  logic [FILL_WIDTH-1:0]   fill0;
  logic [FILL_WIDTH-1:0]   tap_ext;
  logic [FILL_WIDTH-1:0]   tap_plus_one;
  logic                    cfg_accept;
  logic                    fill_inc;
  logic                    drain_step;

  assign tap_ext      = FILL_WIDTH'(tap);
  assign tap_plus_one = tap_ext + 1'b1;

  register_pipeline_variable_fill_counter #(
    .MAX_COUNT (PIPE_DEPTH),
    .WIDTH     (FILL_WIDTH)
  ) u_fill_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == CLEAR),
    .inc     (fill_inc),
    .count   (fill)
  );

  // Next state and all handshake/pipeline controls; config requests win over data in RUN.
  always_comb begin
    state_next           = state;
    in_ready             = 1'b0;
    out_valid            = 1'b0;
    cfg_ready            = 1'b0;
    pipe_shift_data      = 1'b0;
    pipe_clear           = 1'b0;
    pipe_tap_number_load = 1'b0;
    pipe_tap_number      = '0;
    busy                 = 1'b1;
    cfg_accept           = 1'b0;
    fill_inc             = 1'b0;
    drain_step           = 1'b0;
    case (state)
      CLEAR: begin
        pipe_clear = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        pipe_tap_number_load = 1'b1;
        pipe_tap_number      = tap;
        state_next           = RUN;
      end
      RUN: begin
        busy            = 1'b0;
        cfg_ready       = 1'b1;
        out_valid       = (fill > tap_ext);
        in_ready        = !cfg_valid && (!out_valid || out_ready);
        pipe_shift_data = in_valid && in_ready;
        fill_inc        = pipe_shift_data;
        if (cfg_valid) begin
          cfg_accept = 1'b1;
          state_next = cfg_flush ? DRAIN : LOAD;
        end
      end
      DRAIN: begin
        // Bubbles are pushed until every word still inside the old latency window has reached the tap.
        out_valid       = (drain_cnt <= fill0) && (drain_cnt != '0);
        pipe_shift_data = !out_valid || out_ready;
        drain_step      = pipe_shift_data;
        if (pipe_shift_data && (drain_cnt == FILL_WIDTH'(1))) begin
          state_next = CLEAR;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Tap capture on config accept; drain bookkeeping is sized from the old tap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tap       <= ADDR_WIDTH'(DEFAULT_TAP);
      drain_cnt <= '0;
      fill0     <= '0;
    end else begin
      if (cfg_accept) begin
        tap <= cfg_tap;
        if (cfg_flush) begin
          drain_cnt <= tap_plus_one;
          fill0     <= (fill < tap_plus_one) ? fill : tap_plus_one;
        end
      end
      if (drain_step) begin
        drain_cnt <= drain_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_register_pipeline_variable_sequencer.sv
// tb/tb_register_pipeline_variable_sequencer.sv - self-checking bench for the pipeline sequencer
module tb_register_pipeline_variable_sequencer;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int DEF_TAP = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [AW-1:0] cfg_tap = '0;
  logic          cfg_flush = 1'b0;
  logic          pipe_shift_data;
  logic          pipe_clear;
  logic          pipe_tap_number_load;
  logic [AW-1:0] pipe_tap_number;
  logic          busy;
  int unsigned   in_data = 0;

  always #5 clock = ~clock;

  register_pipeline_variable_sequencer #(
    .PIPE_DEPTH  (DEPTH),
    .DEFAULT_TAP (DEF_TAP)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .cfg_valid            (cfg_valid),
    .cfg_ready            (cfg_ready),
    .cfg_tap              (cfg_tap),
    .cfg_flush            (cfg_flush),
    .pipe_shift_data      (pipe_shift_data),
    .pipe_clear           (pipe_clear),
    .pipe_tap_number_load (pipe_tap_number_load),
    .pipe_tap_number      (pipe_tap_number),
    .busy                 (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Environment: the SRL pipeline the sequencer steers (data enters at stage 0, output is stage tap).
  int unsigned srl [DEPTH];
  int          env_tap = 0;

  // Reference model: words in flight in order, count of words since last clear, and phase counters.
  int unsigned q [$];
  int          acc = 0;
  int          mtap = DEF_TAP;
  int          setup = 2;
  int          drain_left = 0;
  bit          model_on = 1'b1;

  int unsigned out_log [$];
  int unsigned pair_log [$];
  int          drain_bubbles = 0;

  always @(negedge clock) begin
    int unsigned cur;
    logic        e_busy;
    logic        e_ov;
    logic        e_ir;
    logic        e_sh;
    cur = srl[env_tap];
    if (!reset_n) begin
      q.delete();
      acc        = 0;
      mtap       = DEF_TAP;
      setup      = 2;
      drain_left = 0;
      chk1("rst_busy", busy, 1'b1);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_cfg_ready", cfg_ready, 1'b0);
      chk1("rst_shift", pipe_shift_data, 1'b0);
    end else begin
      if (out_valid && pipe_shift_data) begin
        out_log.push_back(cur);
        pair_log.push_back(in_ready ? in_data : 32'hFFFF_FFFF);
      end
      if (busy && !out_valid && pipe_shift_data) drain_bubbles++;
      if (model_on) begin
        e_busy = (setup > 0) || (drain_left > 0);
        chk1("busy", busy, e_busy);
        chk1("cfg_ready", cfg_ready, !e_busy);
        chk1("pipe_clear", pipe_clear, setup == 2);
        chk1("tap_load", pipe_tap_number_load, setup == 1);
        if (setup == 1) chkv("tap_number", 32'(pipe_tap_number), mtap);
        if (setup > 0) begin
          e_ov = 1'b0;
          e_ir = 1'b0;
          e_sh = 1'b0;
        end else if (drain_left > 0) begin
          e_ov = (drain_left <= q.size());
          e_ir = 1'b0;
          e_sh = !e_ov || out_ready;
        end else begin
          e_ov = (acc > mtap);
          e_ir = !cfg_valid && (!e_ov || out_ready);
          e_sh = in_valid && e_ir;
        end
        chk1("out_valid", out_valid, e_ov);
        chk1("in_ready", in_ready, e_ir);
        chk1("shift", pipe_shift_data, e_sh);
        if (e_ov && e_sh) begin
          chk1("out_word_expected", q.size() != 0, 1'b1);
          if (q.size() != 0) chkv("out_word", cur, q.pop_front());
        end
        if (setup > 0) begin
          setup--;
        end else if (drain_left > 0) begin
          if (e_sh) begin
            drain_left--;
            if (drain_left == 0) begin
              chkv("flush_all_emitted", q.size(), 0);
              q.delete();
              acc   = 0;
              setup = 2;
            end
          end
        end else if (cfg_valid) begin
          if (cfg_flush) drain_left = mtap + 1;
          else setup = 1;
          mtap = int'(cfg_tap);
        end else if (e_sh) begin
          q.push_back(in_data);
          if (acc < DEPTH) acc++;
        end
      end
    end
    if (pipe_shift_data) begin
      for (int i = DEPTH - 1; i > 0; i--) srl[i] = srl[i-1];
      srl[0] = in_data;
    end
    if (pipe_clear) env_tap = 0;
    if (pipe_tap_number_load) env_tap = int'(pipe_tap_number);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_run(input int max_cycles);
    int n;
    n = 0;
    while (busy && (n < max_cycles)) begin
      step();
      n++;
    end
    chk1("wait_run_timeout", busy, 1'b0);
  endtask

  task automatic push(input int unsigned word);
    in_valid = 1'b1;
    in_data  = word;
    step();
    in_valid = 1'b0;
  endtask

  task automatic request(input int tap, input logic flush);
    cfg_valid = 1'b1;
    cfg_tap   = AW'(tap);
    cfg_flush = flush;
    step();
    cfg_valid = 1'b0;
    cfg_flush = 1'b0;
  endtask

  initial begin
    int unsigned exp_words [4];
    // Reset and bring-up with DEFAULT_TAP = 3
    repeat (3) step();
    reset_n = 1'b1;
    #2;
    chk1("lit_clear_cycle", pipe_clear, 1'b1);
    step(); #2;
    chk1("lit_load_cycle", pipe_tap_number_load, 1'b1);
    chkv("lit_load_tap", 32'(pipe_tap_number), 3);
    step(); #2;
    chk1("lit_run_cfg_ready", cfg_ready, 1'b1);
    chk1("lit_run_out_valid", out_valid, 1'b0);

    // Stream 1..6 at tap 3: latency 4
    out_ready = 1'b1;
    out_log.delete(); pair_log.delete();
    for (int k = 1; k <= 6; k++) push(k);
    #2;
    chkv("lit_stream_count", out_log.size(), 2);
    if (out_log.size() >= 2) begin
      chkv("lit_first_word", out_log[0], 1);
      chkv("lit_first_pair", pair_log[0], 5);
      chkv("lit_second_word", out_log[1], 2);
    end

    // Backpressure: no shift, no input accepted
    out_ready = 1'b0; in_valid = 1'b1; in_data = 7;
    #1;
    chk1("lit_stall_in_ready", in_ready, 1'b0);
    chk1("lit_stall_shift", pipe_shift_data, 1'b0);
    step(); step();
    in_valid = 1'b0; out_ready = 1'b1;

    // Flush from tap 3 with fill 6 to tap 1
    out_log.delete(); drain_bubbles = 0;
    request(1, 1'b1);
    wait_run(20);
    chkv("lit_flush_words", out_log.size(), 4);
    exp_words = '{3, 4, 5, 6};
    if (out_log.size() == 4)
      for (int i = 0; i < 4; i++) chkv("lit_flush_word", out_log[i], exp_words[i]);
    chkv("lit_flush_bubbles", drain_bubbles, 0);
    out_log.delete(); pair_log.delete();
    for (int k = 21; k <= 23; k++) push(k);
    #2;
    chkv("lit_lat2_count", out_log.size(), 1);
    if (out_log.size() == 1) begin
      chkv("lit_lat2_word", out_log[0], 21);
      chkv("lit_lat2_pair", pair_log[0], 23);
    end

    // Tap 5 with only two words, then flush: 4 bubbles then 2 words
    request(5, 1'b1);
    wait_run(20);
    push(31); push(32);
    out_log.delete(); drain_bubbles = 0;
    request(2, 1'b1);
    wait_run(30);
    chkv("lit_tap5_bubbles", drain_bubbles, 4);
    chkv("lit_tap5_words", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chkv("lit_tap5_word0", out_log[0], 31);
      chkv("lit_tap5_word1", out_log[1], 32);
    end

    // Raw retune 3 -> 0 with fill 10: newest word appears
    request(3, 1'b1);
    wait_run(20);
    for (int k = 41; k <= 50; k++) push(k);
    model_on = 1'b0;
    request(0, 1'b0);
    step(); #1;
    chk1("lit_raw_out_valid", out_valid, 1'b1);
    chkv("lit_raw_word", srl[env_tap], 50);

    // Reset while stalled in DRAIN
    out_ready = 1'b0;
    request(3, 1'b1);
    #1;
    chk1("lit_drain_busy", busy, 1'b1);
    chk1("lit_drain_in_ready", in_ready, 1'b0);
    chk1("lit_drain_out_valid", out_valid, 1'b1);
    step(); #1;
    reset_n = 1'b0;
    #1;
    chk1("lit_async_rst_out_valid", out_valid, 1'b0);
    chk1("lit_async_rst_busy", busy, 1'b1);
    model_on = 1'b1;
    step(); step();
    reset_n = 1'b1; out_ready = 1'b1;
    wait_run(5);
    push(61);
    #1;
    chk1("lit_post_rst_fill_zero", out_valid, 1'b0);

    // Randomized traffic with flush retunes
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = $urandom;
      out_ready = ($urandom % 3) != 0;
      cfg_valid = ($urandom % 50) == 0;
      cfg_tap   = AW'($urandom_range(0, DEPTH - 1));
      cfg_flush = 1'b1;
      step();
    end
    in_valid = 1'b0; cfg_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
